wash_panel_ctrl: RTL and testbench

User front-panel controller sitting directly upstream of the washing-machine cycle FSM. Synchronises and debounces the raw panel buttons, holds the selected wash program, locks the door, and converts user presses into the single-cycle `start`, `dry_wash`, `time_pause` strobes and the level `double_wash` that the cycle FSM consumes. Consumes the FSM's `done` to release the door and drive a completion buzzer.

---
 rtl/wash_panel_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_wash_panel_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wash_panel_ctrl.sv
// wash_panel_ctrl -- front-panel controller ahead of the washing-machine cycle FSM.
//
// Synchronises and debounces the three raw panel buttons, holds the selected
// wash program, locks the door and turns user presses into the one-cycle
// start / dry_wash / time_pause strobes and the double_wash level. The cycle
// FSM's done releases the door and sounds the completion buzzer.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   btn_start       raw start button (asynchronous, active-high)
//   btn_mode        raw program-select button (asynchronous, active-high)
//   btn_pause       raw pause button (asynchronous, active-high)
//   door_closed     door sensor, synchronous, 1 = closed
//   done            cycle complete from the cycle FSM
//   start           one-cycle strobe for NORMAL / DOUBLE programs
//   dry_wash        one-cycle strobe for the STEAM program
//   double_wash     level, high while program is DOUBLE in LOCK/RUN
//   time_pause      one-cycle pause strobe
//   program_sel     selected program: 0 NORMAL, 1 DOUBLE, 2 STEAM
//                   (named program_sel because 'program' is a reserved word)
//   door_lock       door locked
//   paused          high during the pause holdoff window
//   buzzer          completion buzzer
//   door_fault      sticky: door opened while running
//   wdog_fault      sticky: run watchdog expired
//
// Optional feature: define PANEL_WATCHDOG_EN to enable the RUN watchdog;
// otherwise wdog_fault is tied low and RUN waits for done indefinitely.
// LOCK_CYCLES must be at least 2.

module wash_panel_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCK_CYCLES     = 3,
  parameter int unsigned PAUSE_HOLDOFF   = 24,
  parameter int unsigned BUZZ_CYCLES     = 8,
  parameter int unsigned WDOG_CYCLES     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_pause,
  input  logic       door_closed,
  input  logic       done,
  output logic       start,
  output logic       dry_wash,
  output logic       double_wash,
  output logic       time_pause,
  output logic [1:0] program_sel,
  output logic       door_lock,
  output logic       paused,
  output logic       buzzer,
  output logic       door_fault,
  output logic       wdog_fault
);

  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LK_W  = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned HO_W  = $clog2(PAUSE_HOLDOFF + 1);
  localparam int unsigned BZ_W  = $clog2(BUZZ_CYCLES + 1);

  localparam logic [DEB_W-1:0] DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [LK_W-1:0]  LOCK_LAST = LK_W'(LOCK_CYCLES - 1);
  localparam logic [HO_W-1:0]  HOLD_MAX  = HO_W'(PAUSE_HOLDOFF);
  localparam logic [BZ_W-1:0]  BUZZ_MAX  = BZ_W'(BUZZ_CYCLES);

  // ---------------- button conditioning ----------------
  // bit 0 = start, bit 1 = mode, bit 2 = pause
  logic [2:0]       raw;
  logic [2:0]       sync1, sync2, deb, deb_q, press;
  logic [DEB_W-1:0] deb_cnt [3];

  assign raw = {btn_pause, btn_mode, btn_start};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      press <= '0;
      for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      press <= deb & ~deb_q;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // ---------------- panel FSM ----------------
  typedef enum logic [1:0] {S_IDLE, S_LOCK, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [LK_W-1:0] lock_cnt;
  logic [HO_W-1:0] hold_cnt;
  logic [BZ_W-1:0] buzz_cnt;

`ifdef PANEL_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign wdog_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      program_sel <= '0;
      start       <= 1'b0;
      dry_wash    <= 1'b0;
      double_wash <= 1'b0;
      time_pause  <= 1'b0;
      door_lock   <= 1'b0;
      paused      <= 1'b0;
      buzzer      <= 1'b0;
      door_fault  <= 1'b0;
      lock_cnt    <= '0;
      hold_cnt    <= '0;
      buzz_cnt    <= '0;
`ifdef PANEL_WATCHDOG_EN
      wdog_fault  <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      start      <= 1'b0;
      dry_wash   <= 1'b0;
      time_pause <= 1'b0;
      case (state)
        S_IDLE: begin
          // a start press in the same cycle as a mode press swallows the
          // mode press even when the door is open and the start is dropped
          if (press[0]) begin
            if (door_closed) begin
              state       <= S_LOCK;
              door_lock   <= 1'b1;
              door_fault  <= 1'b0;
              double_wash <= (program_sel == 2'd1);
              // the entry cycle is the first lock cycle
              lock_cnt    <= LK_W'(1);
`ifdef PANEL_WATCHDOG_EN
              wdog_fault  <= 1'b0;
`endif
            end
          end else if (press[1]) begin
            program_sel <= (program_sel == 2'd2) ? 2'd0 : program_sel + 2'd1;
          end
        end
        S_LOCK: begin
          if (!door_closed) begin
            state       <= S_IDLE;
            door_lock   <= 1'b0;
            double_wash <= 1'b0;
            lock_cnt    <= '0;
          end else if (lock_cnt >= LOCK_LAST) begin
            state    <= S_RUN;
            lock_cnt <= '0;
            if (program_sel == 2'd2) dry_wash <= 1'b1;
            else                     start    <= 1'b1;
`ifdef PANEL_WATCHDOG_EN
            wd_cnt   <= '0;
`endif
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!door_closed) door_fault <= 1'b1;
          if (done) begin
            state       <= S_DONE;
            door_lock   <= 1'b0;
            double_wash <= 1'b0;
            paused      <= 1'b0;
            hold_cnt    <= '0;
            buzzer      <= 1'b1;
            buzz_cnt    <= BZ_W'(1);
          end
`ifdef PANEL_WATCHDOG_EN
          else if (wd_cnt >= WDOG_LAST) begin
            state       <= S_IDLE;
            door_lock   <= 1'b0;
            double_wash <= 1'b0;
            paused      <= 1'b0;
            hold_cnt    <= '0;
            wdog_fault  <= 1'b1;
            wd_cnt      <= '0;
          end
`endif
          else begin
`ifdef PANEL_WATCHDOG_EN
            wd_cnt <= wd_cnt + 1'b1;
`endif
            if (paused) begin
              if (hold_cnt >= HOLD_MAX) begin
                paused   <= 1'b0;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end else if (press[2]) begin
              time_pause <= 1'b1;
              paused     <= 1'b1;
              hold_cnt   <= HO_W'(1);
            end
          end
        end
        S_DONE: begin
          if (buzz_cnt >= BUZZ_MAX) begin
            state    <= S_IDLE;
            buzzer   <= 1'b0;
            buzz_cnt <= '0;
          end else begin
            buzz_cnt <= buzz_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Self-checking bench for wash_panel_ctrl (default build, watchdog disabled).
// Expected values come from the panel's timing rules expressed as offsets
// from the cycle in which a raw button is raised, plus a modulo-3 program
// counter; a negedge monitor only collects event counts and timestamps.

module tb_wash_panel_ctrl;

  localparam int unsigned DEB   = 4;
  localparam int unsigned LOCKC = 3;
  localparam int unsigned HOLD  = 24;
  localparam int unsigned BUZZ  = 8;
  // raw rise after edge E: synchroniser (1) + debounce (DEB+3) + FSM (1)
  localparam int unsigned RISE_TO_ACT    = DEB + 5;
  localparam int unsigned RISE_TO_STROBE = DEB + 4 + LOCKC;

  logic       clk = 1'b0;
  logic       rst, btn_start, btn_mode, btn_pause, door_closed, done;
  logic       start, dry_wash, double_wash, time_pause;
  logic [1:0] program_sel;
  logic       door_lock, paused, buzzer, door_fault, wdog_fault;

  wash_panel_ctrl dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_mode(btn_mode),
    .btn_pause(btn_pause), .door_closed(door_closed), .done(done),
    .start(start), .dry_wash(dry_wash), .double_wash(double_wash),
    .time_pause(time_pause), .program_sel(program_sel), .door_lock(door_lock),
    .paused(paused), .buzzer(buzzer), .door_fault(door_fault),
    .wdog_fault(wdog_fault)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // event monitor
  int unsigned n_start = 0, n_dry = 0, n_tp = 0, n_paused = 0, n_buzz = 0;
  int unsigned start_at = 0, dry_at = 0, tp_at = 0, paused_at = 0, buzz_at = 0, lock_at = 0;
  logic lock_q = 1'b0, paused_q = 1'b0, buzz_q = 1'b0;
  always @(negedge clk) begin
    if (start)    begin n_start++; start_at = cyc; end
    if (dry_wash) begin n_dry++;   dry_at   = cyc; end
    if (time_pause) begin n_tp++;  tp_at    = cyc; end
    if (paused) n_paused++;
    if (buzzer) n_buzz++;
    if (door_lock && !lock_q) lock_at   = cyc;
    if (paused && !paused_q)  paused_at = cyc;
    if (buzzer && !buzz_q)    buzz_at   = cyc;
    lock_q = door_lock; paused_q = paused; buzz_q = buzzer;
  end

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned prog_model = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    tick($urandom_range(8, 12));
    btn_mode = 1'b0;
    tick($urandom_range(10, 14));
    prog_model = (prog_model + 1) % 3;
    chk("program_step", program_sel, prog_model);
  endtask

  task automatic set_prog(input int unsigned tgt);
    for (int k = 0; k < 3 && prog_model != tgt; k++) press_mode();
  endtask

  task automatic do_run(input int unsigned tgt, input int unsigned run_len,
                        input bit use_pause, input bit dopen);
    int unsigned e, a, x, b_s, b_d, b_t, b_p, b_b;
    set_prog(tgt);
    door_closed = 1'b1;
    b_s = n_start; b_d = n_dry;
    e = cyc;
    btn_start = 1'b1;
    tick(10);
    btn_start = 1'b0;
    tick(4);
    chk("lock_rise", lock_at, e + RISE_TO_ACT);
    chk("door_lock_run", door_lock, 1);
    chk("fault_cleared", door_fault, 0);
    chk("n_start", n_start - b_s, (tgt == 2) ? 0 : 1);
    chk("n_dry", n_dry - b_d, (tgt == 2) ? 1 : 0);
    chk("strobe_time", (tgt == 2) ? dry_at : start_at, e + RISE_TO_STROBE);
    chk("double_wash", double_wash, (tgt == 1) ? 1 : 0);
    if (use_pause) begin
      b_t = n_tp; b_p = n_paused;
      a = cyc;
      btn_pause = 1'b1; tick(8); btn_pause = 1'b0; tick(8);
      btn_pause = 1'b1; tick(8); btn_pause = 1'b0; tick(20);
      chk("n_time_pause", n_tp - b_t, 1);
      chk("time_pause_at", tp_at, a + RISE_TO_ACT);
      chk("paused_at", paused_at, a + RISE_TO_ACT);
      chk("paused_len", n_paused - b_p, HOLD);
    end
    if (dopen) begin
      door_closed = 1'b0; tick(3); door_closed = 1'b1; tick(1);
      chk("door_fault_set", door_fault, 1);
      chk("lock_kept", door_lock, 1);
    end
    tick(run_len);
    chk("still_running", door_lock, 1);
    chk("wdog_fault_off", wdog_fault, 0);
    b_b = n_buzz;
    x = cyc;
    done = 1'b1; tick(1); done = 1'b0;
    chk("lock_released", door_lock, 0);
    chk("buzzer_on", buzzer, 1);
    chk("double_wash_off", double_wash, 0);
    tick(BUZZ + 2);
    chk("buzz_at", buzz_at, x + 1);
    chk("buzz_len", n_buzz - b_b, BUZZ);
    if (dopen) chk("door_fault_sticky", door_fault, 1);
  endtask

  initial begin
    int unsigned e, b, t;
    rst = 1'b1; btn_start = 1'b0; btn_mode = 1'b0; btn_pause = 1'b0;
    door_closed = 1'b1; done = 1'b0;
    tick(3);
    chk("reset_outputs", {start, dry_wash, double_wash, time_pause, program_sel,
                          door_lock, paused, buzzer, door_fault, wdog_fault}, 0);
    rst = 1'b0;
    tick(2);

    // program cycling, one step per hold
    for (int i = 0; i < 5; i++) press_mode();

    // short glitch on start must not be accepted
    b = n_start + n_dry;
    btn_start = 1'b1; tick(2); btn_start = 1'b0; tick(14);
    chk("glitch_lock", door_lock, 0);
    chk("glitch_strobe", n_start + n_dry - b, 0);

    // start with the door open is dropped
    door_closed = 1'b0;
    btn_start = 1'b1; tick(10); btn_start = 1'b0; tick(12);
    chk("open_door_start", door_lock, 0);
    door_closed = 1'b1;
    tick(2);

    // done outside RUN is ignored
    b = n_buzz;
    done = 1'b1; tick(1); done = 1'b0; tick(2);
    chk("idle_done_buzz", n_buzz - b, 0);

    // DOUBLE run with pause double-press and a door-open event
    do_run(1, 10, 1'b1, 1'b1);

    // STEAM, door opened during LOCK: back to idle, no dry_wash
    set_prog(2);
    b = n_dry;
    e = cyc;
    btn_start = 1'b1; tick(RISE_TO_ACT);
    chk("lock_entry", door_lock, 1);
    chk("lock_clears_fault", door_fault, 0);
    door_closed = 1'b0; tick(1);
    chk("lock_abort", door_lock, 0);
    tick(1); btn_start = 1'b0;
    tick(6); door_closed = 1'b1; tick(8);
    chk("lock_abort_no_dry", n_dry - b, 0);
    chk("lock_abort_idle", door_lock, 0);
    chk("lock_abort_at", lock_at, e + RISE_TO_ACT);

    // simultaneous start and mode: start wins, program unchanged
    t = $urandom_range(0, 2);
    set_prog(t);
    b = n_start + n_dry;
    btn_start = 1'b1; btn_mode = 1'b1; tick(10);
    btn_start = 1'b0; btn_mode = 1'b0; tick(4);
    chk("both_program", program_sel, t);
    chk("both_strobe", n_start + n_dry - b, 1);
    chk("both_dw", double_wash, (t == 1) ? 1 : 0);
    done = 1'b1; tick(1); done = 1'b0; tick(BUZZ + 2);

    // no watchdog in this build: RUN outlasts WDOG_CYCLES
    do_run(0, 1100, 1'b0, 1'b0);

    // randomized runs
    for (int i = 0; i < 4; i++)
      do_run($urandom_range(0, 2), $urandom_range(5, 40),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // reset mid-run with pause active and door fault set
    set_prog(1);
    btn_start = 1'b1; tick(10); btn_start = 1'b0; tick(4);
    door_closed = 1'b0; tick(2); door_closed = 1'b1;
    btn_pause = 1'b1; tick(8); btn_pause = 1'b0; tick(4);
    chk("pre_reset_paused", paused, 1);
    chk("pre_reset_fault", door_fault, 1);
    rst = 1'b1; tick(1);
    chk("midrun_reset", {start, dry_wash, double_wash, time_pause, program_sel,
                         door_lock, paused, buzzer, door_fault, wdog_fault}, 0);
    rst = 1'b0;
    prog_model = 0;
    tick(12);
    press_mode();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
